fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch sequencer between the PC unit (`pc_if`), instruction memory and decode. It issues one fetch request per PC value and holds the returned instruction until decode accepts it. It then tells the PC unit to advance (sequential) or load a redirect target (branch/jump from execute). It also detects memory timeouts and flushes in-flight fetches on redirect.

## Interface
- `TIMEOUT`, 16: max cycles a request may wait for grant plus response before fault; range 2..255
- `clk`  in  1: clock, all state updates on rising edge
- `rst`  in  1: synchronous, active-high reset
- `curr_pc`  in  32: current PC from PC unit; used as fetch address
- `branch_addr`  out  32: redirect target to PC unit
- `branch_addr_en`  out  1: PC loads `branch_addr` instead of `pc_add4` on this advance
- `inst_ready`  out  1: one-cycle pulse; PC unit updates `curr_pc` at this edge
- `imem_req`  out  1: fetch request, held until `imem_gnt`
- `imem_addr`  out  32: fetch address, stable while `imem_req`
- `imem_gnt`  in  1: request accepted this cycle
- `imem_rvalid`  in  1: response data valid this cycle
- `imem_rdata`  in  32: response data
- `inst`  out  32: instruction to decode
- `inst_pc`  out  32: PC of `inst`
- `inst_valid`  out  1: `inst`/`inst_pc` valid
- `dec_ready`  in  1: decode consumes `inst` when `inst_valid & dec_ready`
- `redirect_en`  in  1: execute redirect request, single-cycle pulse
- `redirect_addr`  in  32: redirect target, bit[1:0] must be 0
- `fetch_fault`  out  1: sticky timeout indicator

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, ADV, FAULT.
- IDLE: entered on reset; next cycle -> REQ.
- REQ: `imem_req=1`, `imem_addr=curr_pc`. On `imem_gnt` -> WAIT. If `imem_rvalid` also arrives in the same cycle as the grant, go straight to HOLD.
- WAIT: on `imem_rvalid`, capture `imem_rdata` into `inst` and `curr_pc` into `inst_pc`, then -> HOLD. Otherwise stay.
- HOLD: `inst_valid=1`. On `dec_ready` -> ADV with `branch_addr_en=0`.
- ADV: one cycle. `inst_ready=1`, `branch_addr_en` per the latched redirect flag. Next state is REQ; the PC value is new from this cycle on.
- Redirect handling:
  - `redirect_en` latches `redirect_addr` into `branch_addr` and sets `redir_pend`.
  - In HOLD: drop the held instruction (`inst_valid` falls next cycle, no consumption) -> ADV with `branch_addr_en=1`.
  - In REQ before grant: deassert `imem_req` -> ADV with `branch_addr_en=1`.
  - In WAIT: set `kill`; the next `imem_rvalid` is discarded, then -> ADV with `branch_addr_en=1`.
  - In ADV: applies to the following fetch. The pending flag causes an extra ADV with `branch_addr_en=1` before the next REQ.
  - In HOLD with `dec_ready=1` in the same cycle: redirect wins; the instruction is not consumed.
  - `redir_pend` clears in the ADV that uses it.
- Timeout:
  - An 8-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT` -> FAULT with `fetch_fault=1`.
  - FAULT holds all requests low and ignores `imem_rvalid`. `redirect_en` leaves FAULT via ADV (`branch_addr_en=1`) and clears `fetch_fault`.
- At most one request outstanding; a response while not in WAIT/REQ-with-grant is ignored.

## Timing
- Reset values: `imem_req=0`, `imem_addr=0`, `inst=0`, `inst_pc=0`, `inst_valid=0`, `inst_ready=0`, `branch_addr=0`, `branch_addr_en=0`, `fetch_fault=0`, state IDLE, counters and flags 0.
- All outputs are registered except `imem_addr`, which is a direct copy of `curr_pc`.
- Latency with zero-wait memory (grant and rvalid in the same cycle):
  - REQ at cycle n, `inst_valid` at n+1.
  - With `dec_ready=1`, ADV at n+2 and next REQ at n+3, giving 3 cycles per instruction.
- Grant the cycle after REQ and rvalid 1 cycle later: `inst_valid` 3 cycles after REQ entry.
- `inst_ready` is high exactly one cycle per advance. `branch_addr` is stable for the whole cycle `branch_addr_en=1`.
- Reset mid-operation:
  - Pending redirect, kill flag and timeout are discarded.
  - Any late `imem_rvalid` after reset is ignored, since IDLE/REQ do not accept responses without a grant.

## Test plan
- Sequential fetch: zero-wait memory, `dec_ready=1`, PC from 0x0 -> `imem_addr` 0x0, 0x4, 0x8 at 3-cycle spacing; `inst_pc` matches; 3 `inst_ready` pulses with `branch_addr_en=0`.
- Decode stall: hold `dec_ready=0` for 5 cycles in HOLD -> `inst_valid` held, `inst` unchanged, no `inst_ready`, no new `imem_req`.
- Redirect in WAIT: grant at 0x10, assert `redirect_en` with 0x200 before rvalid -> rvalid data discarded (`inst_valid` stays 0); ADV with `branch_addr_en=1`, `branch_addr=0x200`; next `imem_addr=0x200`.
- Redirect vs consume collision in HOLD: `redirect_en` and `dec_ready` in the same cycle -> instruction not consumed, single ADV with `branch_addr_en=1`.
- Timeout: `TIMEOUT=4`, never grant -> FAULT after 4 REQ cycles, `imem_req=0`, `fetch_fault=1`. A later `redirect_en` with 0x80 -> fault cleared, fetch at 0x80.
- Reset mid-WAIT: assert `rst` for 1 cycle, then rvalid arrives -> ignored, outputs at reset values, fresh REQ on `curr_pc`.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one memory request per PC value, holds the returned
// instruction for decode, then advances the PC sequentially or to a redirect target.
module fetch_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] curr_pc,
    output logic [31:0] branch_addr,
    output logic        branch_addr_en,
    output logic        inst_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        dec_ready,
    input  logic        redirect_en,
    input  logic [31:0] redirect_addr,
    output logic        fetch_fault,
    output logic [2:0]  dbg_state
);

    // Handshakes: imem_req is held until the cycle imem_gnt is seen; decode consumes
    // inst when inst_valid & dec_ready; inst_ready is a one-cycle PC advance strobe.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        ADV   = 3'd4,
        FAULT = 3'd5
    } state_t;

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    state_t      r_state;
    state_t      w_next;
    logic        r_imem_req;
    logic        r_inst_valid;
    logic        r_inst_ready;
    logic        r_bae;
    logic        r_fault;
    logic        r_kill;
    logic        r_redir_pend;
    logic [7:0]  r_cnt;
    logic [31:0] r_branch_addr;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;

    logic        w_redir;
    logic        w_timeout;
    logic        w_bae_nxt;
    logic        w_kill_nxt;
    logic        w_capture;
    logic [7:0]  w_cnt_inc;

    assign w_redir   = redirect_en | r_redir_pend;
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_timeout = (w_cnt_inc >= LP_TIMEOUT);

    always_comb begin
        w_next     = r_state;
        w_bae_nxt  = 1'b0;
        w_kill_nxt = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            IDLE: w_next = REQ;
            REQ: begin
                if (imem_gnt) begin
                    if (imem_rvalid) begin
                        if (w_redir) begin
                            w_next    = ADV;
                            w_bae_nxt = 1'b1;
                        end else begin
                            w_next    = HOLD;
                            w_capture = 1'b1;
                        end
                    end else begin
                        // Granted request is now in flight; a redirect must kill its response.
                        w_next     = WAIT;
                        w_kill_nxt = w_redir;
                    end
                end else if (w_redir) begin
                    w_next    = ADV;
                    w_bae_nxt = 1'b1;
                end else if (w_timeout) begin
                    w_next = FAULT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (r_kill || w_redir) begin
                        w_next    = ADV;
                        w_bae_nxt = 1'b1;
                    end else begin
                        w_next    = HOLD;
                        w_capture = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next = FAULT;
                end else begin
                    w_kill_nxt = r_kill | w_redir;
                end
            end
            HOLD: begin
                // Redirect wins over a same-cycle consume; the held instruction is dropped.
                if (w_redir) begin
                    w_next    = ADV;
                    w_bae_nxt = 1'b1;
                end else if (dec_ready) begin
                    w_next = ADV;
                end
            end
            ADV: begin
                if (w_redir) begin
                    w_next    = ADV;
                    w_bae_nxt = 1'b1;
                end else begin
                    w_next = REQ;
                end
            end
            FAULT: begin
                if (w_redir) begin
                    w_next    = ADV;
                    w_bae_nxt = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_imem_req    <= 1'b0;
            r_inst_valid  <= 1'b0;
            r_inst_ready  <= 1'b0;
            r_bae         <= 1'b0;
            r_fault       <= 1'b0;
            r_kill        <= 1'b0;
            r_redir_pend  <= 1'b0;
            r_cnt         <= 8'd0;
            r_branch_addr <= 32'd0;
            r_inst        <= 32'd0;
            r_inst_pc     <= 32'd0;
        end else begin
            r_state      <= w_next;
            r_imem_req   <= (w_next == REQ);
            r_inst_valid <= (w_next == HOLD);
            r_inst_ready <= (w_next == ADV);
            r_bae        <= w_bae_nxt;
            r_fault      <= (w_next == FAULT);
            r_kill       <= w_kill_nxt;
            if (redirect_en) begin
                r_branch_addr <= redirect_addr;
            end
            // The ADV that carries branch_addr_en consumes the pending redirect.
            if (w_bae_nxt) begin
                r_redir_pend <= 1'b0;
            end else if (redirect_en) begin
                r_redir_pend <= 1'b1;
            end
            if (w_capture) begin
                r_inst    <= imem_rdata;
                r_inst_pc <= curr_pc;
            end
            if ((w_next == REQ) && (r_state != REQ)) begin
                r_cnt <= 8'd0;
            end else if ((r_state == REQ) || (r_state == WAIT)) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign imem_addr      = curr_pc;
    assign imem_req       = r_imem_req;
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign inst_valid     = r_inst_valid;
    assign inst_ready     = r_inst_ready;
    assign branch_addr    = r_branch_addr;
    assign branch_addr_en = r_bae;
    assign fetch_fault    = r_fault;
    assign dbg_state      = r_state;

endmodule
